mem_arb_req_tracker: RTL and testbench
======================================

Name: mem_arb_req_tracker

Overview:
Downstream stage of the priority arbiter on the core-to-memory path.
- Accepts one granted request at a time over the arbiter's valid/ready/winner handshake.
- Latches the winning client's request, issues it to main memory and waits for the response.
- Routes the response back to the owning client.
- Drives the arbiter's top_client input round-robin, so no client starves behind the highest-index priority.

Parameters:
NUM_CLIENTS, 4, number of requesting clients (any value >= 2, not necessarily a power of two)
NUM_CLIENTS_LOG, $clog2(NUM_CLIENTS), width of client index
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 128, request/response data width (one cache line)

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
arb_valid  input  1  arbiter has at least one valid client
arb_winner  input  NUM_CLIENTS_LOG  index of granted client
arb_ready  output  1  tracker can accept a grant this cycle
top_client  output  NUM_CLIENTS_LOG  preferred client fed back to the arbiter
client_req_addr  input  NUM_CLIENTS*ADDR_WIDTH  per-client address, client i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
client_req_is_store  input  NUM_CLIENTS  per-client store flag
client_req_data  input  NUM_CLIENTS*DATA_WIDTH  per-client store data, same slicing
mem_req_valid  output  1  request to memory valid
mem_req_ready  input  1  memory accepts the request
mem_req_addr  output  ADDR_WIDTH  latched address
mem_req_is_store  output  1  latched store flag
mem_req_data  output  DATA_WIDTH  latched store data
mem_rsp_valid  input  1  memory response/ack valid, one cycle
mem_rsp_data  input  DATA_WIDTH  load data (don't-care for stores)
client_rsp_valid  output  NUM_CLIENTS  one-hot response strobe to the owner
client_rsp_data  output  DATA_WIDTH  response data, shared by all clients
busy  output  1  state != IDLE

Behaviour:
States: IDLE, ISSUE, WAIT_RSP, RESPOND (3-bit or 2-bit enum).

Reset (async, any state):
- State = IDLE, top_client = 0, owner = 0.
- mem_req_valid = 0, client_rsp_valid = 0, busy = 0.
- Latched addr/data/is_store and client_rsp_data = 0.
- An in-flight transaction is dropped: no client_rsp is ever generated for it, and any mem_rsp arriving later in IDLE is ignored.

IDLE:
- arb_ready = 1.
- On arb_valid & arb_ready at cycle N: latch owner = arb_winner, plus that client's addr, is_store and data. Go to ISSUE.
- mem_req_valid first asserts at N+1.

ISSUE:
- arb_ready = 0, mem_req_valid = 1.
- mem_req_* outputs stay stable until mem_req_ready = 1, then go to WAIT_RSP.
- A mem_rsp_valid seen in ISSUE is a protocol error and is ignored.

WAIT_RSP:
- mem_req_valid = 0.
- Loads and stores both wait for exactly one mem_rsp_valid.
- On mem_rsp_valid (including the first cycle in WAIT_RSP): latch mem_rsp_data into client_rsp_data, go to RESPOND.

RESPOND (one cycle):
- client_rsp_valid[owner] = 1, all other bits 0.
- client_rsp_data holds the latched data; it stays stable until the next response.
- top_client <= (owner == NUM_CLIENTS-1) ? 0 : owner+1. Explicit wrap; never produce an index >= NUM_CLIENTS.
- Next state IDLE.

Timing and throughput:
- Minimum grant-to-response latency is 3 cycles: accept N, issue N+1 with ready, rsp N+2, client_rsp_valid at N+3.
- Back-to-back: next grant is accepted in the cycle after RESPOND. Throughput is at most 1 transaction per 4 cycles.

Other rules:
- top_client changes only in RESPOND. It is stable while arb_ready is high.
- arb_winner is sampled only on the accept cycle. client_req_* are also sampled only then; clients must hold them while their client_valid is high.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum tracker_state_t
  - struct mem_req_t {addr, is_store, data}, parameterised widths via package localparams
  - MEM_DATA_WIDTH and MEM_ADDR_WIDTH constants reused by the caches
- One sub-module is natural: rr_next_client (combinational owner -> next index with non-power-of-two wrap). It is reused by other round-robin arbiters in the codebase.

Test Plan:
1. Reset, then client 2 load addr 0x100, mem_req_ready immediate, rsp data 0xA5.. two cycles later:
   - mem_req_valid at N+1 with addr 0x100
   - client_rsp_valid = 4'b0100 at N+3 with data 0xA5..
   - top_client = 3
2. Owner 3 (NUM_CLIENTS=4) completes -> top_client wraps to 0. Repeat with NUM_CLIENTS=3, owner 2 -> top_client = 0, never 3.
3. mem_req_ready held low 5 cycles in ISSUE:
   - mem_req_addr/data/is_store stay stable
   - arb_ready = 0 throughout
   - changing client_req_* inputs has no effect
4. Store from client 0, data 0xDEAD.., ack via mem_rsp_valid -> mem_req_is_store = 1, client_rsp_valid = 4'b0001 exactly one cycle.
5. Spurious mem_rsp_valid in IDLE and in ISSUE -> ignored; no client_rsp_valid; state unaffected.
6. Assert reset in WAIT_RSP, then deliver mem_rsp_valid after release -> no client_rsp_valid; top_client = 0; arb_ready = 1 the first cycle after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the core-to-memory arbitration path.
//   tracker_state_t : request tracker FSM states
//   mem_req_t       : one memory request (address, store flag, line data)
//   MEM_ADDR_WIDTH / MEM_DATA_WIDTH : memory-side widths shared with the caches
package mem_arb_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESPOND  = 2'd3
  } tracker_state_t;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      is_store;
    logic [MEM_DATA_WIDTH-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/rr_next_client.sv
// Round-robin successor: cur -> cur+1, wrapping to 0 after NUM_CLIENTS-1.
// Works for non-power-of-two client counts; any out-of-range input also
// maps to 0 so the result is always a legal client index.
//   cur : current client index
//   nxt : next client index
module rr_next_client #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] nxt
);

  always_comb begin
    if (cur >= IDX_W'(NUM_CLIENTS - 1)) nxt = '0;
    else                                nxt = cur + 1'b1;
  end

endmodule

// File: rtl/mem_arb_req_tracker.sv
// Single-outstanding request tracker sitting behind the priority arbiter.
// Accepts one grant, latches the winner's request, issues it to memory,
// waits for the single response/ack, strobes it back to the owner and
// advances top_client round-robin.
//   clock, reset            : clock, async active-high reset
//   arb_valid/arb_winner    : grant from the arbiter; arb_ready = idle
//   top_client              : preferred client fed back to the arbiter
//   client_req_*            : per-client request buses (sampled on accept)
//   mem_req_*               : request to memory (valid/ready)
//   mem_rsp_valid/data      : one-cycle memory response
//   client_rsp_valid/data   : one-hot response strobe + shared data
//   busy                    : tracker not idle
module mem_arb_req_tracker
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS     = 4,
  parameter int NUM_CLIENTS_LOG = $clog2(NUM_CLIENTS),
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              arb_valid,
  input  logic [NUM_CLIENTS_LOG-1:0]        arb_winner,
  output logic                              arb_ready,
  output logic [NUM_CLIENTS_LOG-1:0]        top_client,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_req_addr,
  input  logic [NUM_CLIENTS-1:0]            client_req_is_store,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_req_data,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic                              mem_req_is_store,
  output logic [DATA_WIDTH-1:0]             mem_req_data,
  input  logic                              mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_rsp_data,
  output logic [NUM_CLIENTS-1:0]            client_rsp_valid,
  output logic [DATA_WIDTH-1:0]             client_rsp_data,
  output logic                              busy
);

  tracker_state_t              state_q, state_d;
  logic [NUM_CLIENTS_LOG-1:0]  owner_q, owner_d;
  logic [NUM_CLIENTS_LOG-1:0]  top_client_q, top_client_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        is_store_q, is_store_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic [NUM_CLIENTS_LOG-1:0]  next_client;

  rr_next_client #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (NUM_CLIENTS_LOG)
  ) u_rr_next (
    .cur (owner_q),
    .nxt (next_client)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    top_client_d = top_client_q;
    addr_d       = addr_q;
    is_store_d   = is_store_q;
    data_d       = data_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_winner;
          // Explicit per-client mux keeps every select in range even when
          // the winner encoding has unused codes (non-power-of-two counts).
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_winner == NUM_CLIENTS_LOG'(i)) begin
              addr_d     = client_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              is_store_d = client_req_is_store[i];
              data_d     = client_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = ST_ISSUE;
        end
      end
      // Responses arriving here are protocol errors and are dropped.
      ST_ISSUE: if (mem_req_ready) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_data_d = mem_rsp_data;
          state_d    = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        top_client_d = next_client;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      top_client_q <= '0;
      addr_q       <= '0;
      is_store_q   <= 1'b0;
      data_q       <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      top_client_q <= top_client_d;
      addr_q       <= addr_d;
      is_store_q   <= is_store_d;
      data_q       <= data_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // All outputs are pure decodes of flops, so no input-to-output paths.
  always_comb begin
    client_rsp_valid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      client_rsp_valid[i] = (state_q == ST_RESPOND) && (owner_q == NUM_CLIENTS_LOG'(i));
  end

  assign arb_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign mem_req_valid    = (state_q == ST_ISSUE);
  assign mem_req_addr     = addr_q;
  assign mem_req_is_store = is_store_q;
  assign mem_req_data     = data_q;
  assign client_rsp_data  = rsp_data_q;
  assign top_client       = top_client_q;

endmodule

// File: tb/tb_mem_arb_req_tracker.sv
module tb_mem_arb_req_tracker;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  typedef struct { logic [AW-1:0] addr; logic st; logic [DW-1:0] data; } req_t;
  typedef struct { int own; logic [DW-1:0] data; } rsp_t;

  logic clock = 0;
  logic reset;
  always #5 clock = ~clock;

  // 4-client DUT
  logic           arb_valid, arb_ready, mem_req_valid, mem_req_ready, mem_req_is_store;
  logic           mem_rsp_valid, busy;
  logic [1:0]     arb_winner, top_client;
  logic [NC*AW-1:0] client_req_addr;
  logic [NC-1:0]  client_req_is_store, client_rsp_valid;
  logic [NC*DW-1:0] client_req_data;
  logic [AW-1:0]  mem_req_addr;
  logic [DW-1:0]  mem_req_data, mem_rsp_data, client_rsp_data;

  // 3-client DUT (non-power-of-two wrap)
  logic           arb_valid3, arb_ready3, mem_req_valid3, mem_req_ready3, mem_req_is_store3;
  logic           mem_rsp_valid3, busy3;
  logic [1:0]     arb_winner3, top_client3;
  logic [3*AW-1:0] client_req_addr3;
  logic [2:0]     client_req_is_store3, client_rsp_valid3;
  logic [3*DW-1:0] client_req_data3;
  logic [AW-1:0]  mem_req_addr3;
  logic [DW-1:0]  mem_req_data3, mem_rsp_data3, client_rsp_data3;

  mem_arb_req_tracker #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .arb_valid(arb_valid), .arb_winner(arb_winner),
    .arb_ready(arb_ready), .top_client(top_client), .client_req_addr(client_req_addr),
    .client_req_is_store(client_req_is_store), .client_req_data(client_req_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_is_store(mem_req_is_store), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .client_rsp_valid(client_rsp_valid), .client_rsp_data(client_rsp_data), .busy(busy));

  mem_arb_req_tracker #(.NUM_CLIENTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
    .clock(clock), .reset(reset), .arb_valid(arb_valid3), .arb_winner(arb_winner3),
    .arb_ready(arb_ready3), .top_client(top_client3), .client_req_addr(client_req_addr3),
    .client_req_is_store(client_req_is_store3), .client_req_data(client_req_data3),
    .mem_req_valid(mem_req_valid3), .mem_req_ready(mem_req_ready3), .mem_req_addr(mem_req_addr3),
    .mem_req_is_store(mem_req_is_store3), .mem_req_data(mem_req_data3),
    .mem_rsp_valid(mem_rsp_valid3), .mem_rsp_data(mem_rsp_data3),
    .client_rsp_valid(client_rsp_valid3), .client_rsp_data(client_rsp_data3), .busy(busy3));

  int checks = 0;
  int failures = 0;
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int exp_top = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble_clients();
    for (int i = 0; i < NC; i++) begin
      client_req_addr[i*AW +: AW] = $urandom;
      client_req_data[i*DW +: DW] = rnd_line();
      client_req_is_store[i]      = 1'($urandom_range(0, 1));
    end
  endtask

  // Scoreboard monitor: mid-cycle sampling, expectations come from the queues.
  always @(negedge clock) begin
    rsp_t r;
    if (!reset) begin
      if (mem_req_valid) begin
        chk("arb_ready_while_issuing", arb_ready, 0);
        if (exp_req_q.size() == 0) chk("mem_req_unexpected", mem_req_valid, 0);
        else begin
          // Checked every ISSUE cycle, so a drifting request is caught too.
          chk("mem_req_addr", mem_req_addr, exp_req_q[0].addr);
          chk("mem_req_is_store", mem_req_is_store, exp_req_q[0].st);
          chk("mem_req_data", mem_req_data, exp_req_q[0].data);
          if (mem_req_ready) void'(exp_req_q.pop_front());
        end
      end
      if (client_rsp_valid != 0) begin
        if (exp_rsp_q.size() == 0) chk("client_rsp_unexpected", client_rsp_valid, 0);
        else begin
          r = exp_rsp_q.pop_front();
          chk("client_rsp_valid", client_rsp_valid, NC'(1) << r.own);
          chk("client_rsp_data", client_rsp_data, r.data);
          exp_top = (r.own + 1) % NC;
        end
      end
      if (arb_ready) chk("top_client", top_client, exp_top);
      if (top_client3 >= 2'd3) chk("top_client3_range", top_client3, 0);
    end
  end

  // One full transaction as arbiter + memory.
  task automatic do_txn(input int w, input logic [AW-1:0] a, input logic st,
                        input logic [DW-1:0] d, input int stall, input int dly,
                        input logic [DW-1:0] rd, input bit spur);
    int guard;
    guard = 0;
    while (!arb_ready && guard < 20) begin @(posedge clock); #1; guard++; end
    if (!arb_ready) begin chk("arb_ready_timeout", arb_ready, 1); return; end
    if (spur) begin
      mem_rsp_valid = 1; mem_rsp_data = rnd_line();
      @(posedge clock); #1;
      mem_rsp_valid = 0;
      chk("spurious_idle_busy", busy, 0);
    end
    scramble_clients();
    client_req_addr[w*AW +: AW] = a;
    client_req_is_store[w]      = st;
    client_req_data[w*DW +: DW] = d;
    arb_winner = 2'(w); arb_valid = 1;
    exp_req_q.push_back('{addr: a, st: st, data: d});
    @(posedge clock); #1;
    arb_valid = 0; arb_winner = 2'($urandom); scramble_clients();
    chk("issue_latency_valid", mem_req_valid, 1);
    for (int i = 0; i < stall; i++) begin
      arb_valid = 1'($urandom_range(0, 1));
      if (spur && i == 0) begin mem_rsp_valid = 1; mem_rsp_data = rnd_line(); end
      @(posedge clock); #1;
      mem_rsp_valid = 0; scramble_clients();
      chk("stall_still_issuing", mem_req_valid, 1);
    end
    arb_valid = 0;
    mem_req_ready = 1;
    @(posedge clock); #1;
    mem_req_ready = 0;
    for (int i = 0; i < dly; i++) begin
      @(posedge clock); #1;
      chk("wait_no_rsp", client_rsp_valid, 0);
    end
    mem_rsp_valid = 1; mem_rsp_data = rd;
    exp_rsp_q.push_back('{own: w, data: rd});
    @(posedge clock); #1;
    mem_rsp_valid = 0; mem_rsp_data = rnd_line();
    chk("respond_strobe", client_rsp_valid, NC'(1) << w);
    @(posedge clock); #1;
    chk("respond_one_cycle", client_rsp_valid, 0);
    chk("top_after_rsp", top_client, (w + 1) % NC);
  endtask

  task automatic txn3(input int w);
    arb_winner3 = 2'(w); arb_valid3 = 1;
    @(posedge clock); #1;
    arb_valid3 = 0; mem_req_ready3 = 1;
    @(posedge clock); #1;
    mem_req_ready3 = 0; mem_rsp_valid3 = 1; mem_rsp_data3 = rnd_line();
    @(posedge clock); #1;
    mem_rsp_valid3 = 0;
    chk("rsp3_strobe", client_rsp_valid3, 3'(1) << w);
    @(posedge clock); #1;
    chk("top3_wrap", top_client3, (w + 1) % 3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    arb_valid = 0; arb_winner = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    client_req_addr = '0; client_req_is_store = '0; client_req_data = '0;
    arb_valid3 = 0; arb_winner3 = 0; mem_req_ready3 = 0; mem_rsp_valid3 = 0; mem_rsp_data3 = 0;
    client_req_addr3 = '0; client_req_is_store3 = '0; client_req_data3 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_arb_ready", arb_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_top_client", top_client, 0);
    chk("rst_client_rsp_valid", client_rsp_valid, 0);
    chk("rst_client_rsp_data", client_rsp_data, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_data", mem_req_data, 0);

    // Client 2 load, minimum latency.
    do_txn(2, 32'h100, 0, rnd_line(), 0, 0, {16{8'hA5}}, 0);
    // Client 3 -> top_client wraps to 0.
    do_txn(3, $urandom, 0, rnd_line(), 0, 1, rnd_line(), 0);
    // Long stall with changing inputs and a spurious response in ISSUE/IDLE.
    do_txn(1, 32'hCAFE_0000, 0, rnd_line(), 5, 0, rnd_line(), 1);
    // Store from client 0.
    do_txn(0, 32'h2000, 1, {8{16'hDEAD}}, 0, 2, rnd_line(), 0);

    for (int n = 0; n < 40; n++)
      do_txn($urandom_range(0, NC - 1), $urandom, 1'($urandom_range(0, 1)), rnd_line(),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
             $urandom_range(0, 3), rnd_line(), $urandom_range(0, 3) == 0);

    // Reset while waiting for the response: transaction is dropped.
    do_txn(1, 32'h300, 0, rnd_line(), 0, 0, rnd_line(), 0);
    scramble_clients();
    arb_winner = 2'd2; arb_valid = 1;
    exp_req_q.push_back('{addr: client_req_addr[2*AW +: AW], st: client_req_is_store[2],
                          data: client_req_data[2*DW +: DW]});
    @(posedge clock); #1;
    arb_valid = 0; mem_req_ready = 1;
    @(posedge clock); #1;
    mem_req_ready = 0;
    #2 reset = 1; exp_top = 0;
    #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_top", top_client, 0);
    chk("rst_wait_rsp_data", client_rsp_data, 0);
    @(posedge clock); #1 reset = 0;
    chk("post_rst_arb_ready", arb_ready, 1);
    mem_rsp_valid = 1; mem_rsp_data = rnd_line();
    @(posedge clock); #1;
    mem_rsp_valid = 0;
    chk("post_rst_no_rsp", client_rsp_valid, 0);
    chk("post_rst_idle", busy, 0);
    @(posedge clock); #1;
    chk("post_rst_no_rsp2", client_rsp_valid, 0);

    // Three-client instance: wrap from 2 must give 0.
    txn3(2); txn3(0); txn3(1); txn3(2);

    repeat (3) @(posedge clock); #1;
    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("rsp_queue_drained", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
